input_feed_sched: RTL and testbench
===================================

Name: input_feed_sched

Overview:
Sequences the per-row activation and weight input buffers that feed the systolic array, producing the diagonal skew the array requires: row i starts streaming i cycles after row 0. For each tile it issues K reads per row and stalls the whole wavefront whenever an active buffer is empty. After the last read it drains the array for a fixed number of cycles, then reports completion. It sits between the host/tile sequencer and the bank of input buffers.

Parameters:
ROWS, 8, number of array rows, which is also the number of activation buffers and the number of weight buffers
KW, 8, width of k_len; maximum tile depth is 2^KW-1
DRAIN, 16, number of array-flush cycles after the last read step; must be at least 1

Ports:
clk  input  1  clock
rst  input  1  reset
start  input  1  tile start request, single-cycle pulse
k_len  input  KW  tile depth K (reads per row), sampled when start is accepted
aempty  input  ROWS  per-row activation buffer empty flags
wempty  input  ROWS  per-row weight buffer empty flags
aread  output  ROWS  per-row activation buffer read enables
wread  output  ROWS  per-row weight buffer read enables
feed_valid  output  ROWS  buffer dout for row i is valid this cycle
array_en  output  1  advance the systolic array this cycle
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle completion pulse

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset: state=IDLE; step counter and drain counter cleared; latched K cleared; aread, wread, feed_valid, array_en, busy and done all 0. Reset asserted mid-tile aborts the tile: outputs are 0 in the cycle after rst is sampled and no done pulse is produced. This block does not flush the buffers.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE:
  - If start=1 and k_len>0: latch K, set t=0, next state RUN.
  - If start=1 and k_len=0: next state DONE. No reads are issued.
  - Otherwise: go to or remain in IDLE.
- RUN, step counter t from 0 to K+ROWS-2 (width sized for 2^KW+ROWS):
  - Row i is active when i <= t < i+K.
  - stall = OR over active rows of (aempty[i] | wempty[i]).
  - aread[i] = wread[i] = active[i] & ~stall. These are combinational from registered t, K and the empty flags.
  - When stall=0, t increments. On the step where t=K+ROWS-2 and stall=0, next state is DRAIN with drain counter 0.
  - When stall=1, t holds and all reads are 0.
- feed_valid[i] is aread[i] registered one cycle, matching the buffers' one-cycle registered read latency.
- array_en is the registered value of (RUN & ~stall) OR (DRAIN). It therefore lags each accepted step by one cycle and stays high for every DRAIN cycle. array_en is 0 for stalled steps.
- DRAIN: no reads. The counter runs 0 to DRAIN-1; on its last cycle, next state is DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. A start in the DONE cycle is accepted as in IDLE.
- A start during RUN or DRAIN is ignored. k_len changes after acceptance have no effect.
- Read-count invariant: each row receives exactly K aread and exactly K wread pulses per tile. aread[i] and wread[i] are always equal.
- Timing: start is sampled at cycle c. RUN starts at c+1. Read steps take K+ROWS-1 cycles plus stall cycles. DRAIN follows with DRAIN cycles, then done.

Test Plan:
- Reset values: ROWS=4, K=3, DRAIN=4, all buffers non-empty, start at cycle 0 -> reads on row0 at cycles 1-3, row1 at 2-4, row2 at 3-5, row3 at 4-6. feed_valid[i] follows aread[i] by one cycle. array_en high for cycles 2-11. busy high for cycles 1-10. done at cycle 11.
- Stall: same setup, with aempty[2]=1 during cycle 4 only -> no reads at cycle 4. Row2 reads move to cycles 3, 5 and 6; row3 reads to cycles 5-7. array_en low at cycle 5. done at cycle 12. Each row still gets exactly 3 reads.
- Inactive-row empties do not stall: wempty[3]=1 during cycles 1-3 -> schedule identical to the first scenario.
- k_len=0 with start -> done at cycle 1, no reads, busy stays 0.
- Start while busy, and back-to-back tiles: a start at cycle 5 is ignored. A start at done cycle 11 with K=2 -> row0 reads at cycles 12-13.
- Reset mid-RUN: rst at cycle 3 -> all outputs 0 from cycle 4. No done pulse. A later start behaves as from a fresh reset.

Source files
------------

// File: rtl/input_feed_sched.sv
// Input buffer sequencer for the systolic array: issues K skewed reads per row
// (row i lags row 0 by i cycles), stalls the wavefront on empty buffers, then drains.
module input_feed_sched #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned KW    = 8,
  parameter int unsigned DRAIN = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic [ROWS-1:0] aempty,
  input  logic [ROWS-1:0] wempty,
  output logic [ROWS-1:0] aread,
  output logic [ROWS-1:0] wread,
  output logic [ROWS-1:0] feed_valid,
  output logic            array_en,
  output logic            busy,
  output logic            done
);

  localparam int unsigned TW = KW + $clog2(ROWS) + 1;
  localparam int unsigned DW = $clog2(DRAIN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   t, t_nxt;
  logic [DW-1:0]   dcnt, dcnt_nxt;
  logic [KW-1:0]   k_q, k_nxt;
  logic [ROWS-1:0] active;
  logic            stall;
  logic            last_step;
  logic            en_nxt;

  // Diagonal wavefront: row i reads during steps i .. i+K-1
  always_comb begin
    active = '0;
    if (state == S_RUN) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        active[i] = (t >= TW'(i)) && (t < TW'(i) + TW'(k_q));
      end
    end
    stall     = |(active & (aempty | wempty));
    aread     = stall ? '0 : active;
    wread     = stall ? '0 : active;
    last_step = (t + TW'(1)) == (TW'(k_q) + TW'(ROWS - 1));
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    dcnt_nxt  = dcnt;
    k_nxt     = k_q;
    en_nxt    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (start) begin
          if (k_len != '0) begin
            k_nxt     = k_len;
            t_nxt     = '0;
            state_nxt = S_RUN;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (!stall) begin
          en_nxt = 1'b1;
          if (last_step) begin
            state_nxt = S_DRAIN;
            dcnt_nxt  = '0;
          end else begin
            t_nxt = t + TW'(1);
          end
        end
      end
      S_DRAIN: begin
        en_nxt = 1'b1;
        if (dcnt == DW'(DRAIN - 1)) begin
          state_nxt = S_DONE;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs; busy/done are taken from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      t          <= '0;
      dcnt       <= '0;
      k_q        <= '0;
      feed_valid <= '0;
      array_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      t          <= t_nxt;
      dcnt       <= dcnt_nxt;
      k_q        <= k_nxt;
      feed_valid <= aread;
      array_en   <= en_nxt;
      busy       <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      done       <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_input_feed_sched.sv
// Scoreboard bench for input_feed_sched: per-cycle expected outputs derived from
// the documented tile schedule are queued with the stimulus and compared on pop.
module tb_input_feed_sched;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned KW    = 8;
  localparam int unsigned DRAIN = 4;
  localparam int NC = 40;

  logic            clk, rst, start;
  logic [KW-1:0]   k_len;
  logic [ROWS-1:0] aempty, wempty, aread, wread, feed_valid;
  logic            array_en, busy, done;

  input_feed_sched #(.ROWS(ROWS), .KW(KW), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .aempty(aempty), .wempty(wempty), .aread(aread), .wread(wread),
    .feed_valid(feed_valid), .array_en(array_en), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROWS-1:0] rd;
    logic [ROWS-1:0] fv;
    logic            en;
    logic            bsy;
    logic            dn;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  string cur;

  // stimulus and expectation tables, indexed by cycle (cycle 0 = first start)
  logic            st[NC], rs[NC];
  logic [KW-1:0]   kl[NC];
  logic [ROWS-1:0] ae[NC], we[NC];
  logic [ROWS-1:0] e_rd[NC], e_fv[NC];
  logic            e_en[NC], e_busy[NC], e_done[NC];
  int              rd_cnt[ROWS];

  task automatic clear_tables();
    for (int c = 0; c < NC; c++) begin
      st[c] = 0; rs[c] = 0; kl[c] = 8'd7; ae[c] = '0; we[c] = '0;
      e_rd[c] = '0; e_fv[c] = '0; e_en[c] = 0; e_busy[c] = 0; e_done[c] = 0;
    end
    for (int i = 0; i < ROWS; i++) rd_cnt[i] = 0;
  endtask

  function automatic int shifted(int c, int stall_at);
    return (stall_at >= 0 && c >= stall_at) ? c + 1 : c;
  endfunction

  function automatic bit ok(int c);
    return c >= 0 && c < NC;
  endfunction

  // Expected tile from start at cycle s: row i reads cycles s+1+i .. s+i+K,
  // with everything at or after stall_at pushed one cycle later.
  task automatic add_tile(int s, int k, int stall_at);
    int c, last;
    if (k == 0) begin
      if (ok(s + 1)) e_done[s + 1] = 1;
      return;
    end
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < k; j++) begin
        c = shifted(s + 1 + i + j, stall_at);
        if (ok(c)) e_rd[c][i] = 1'b1;
        if (ok(c + 1)) e_fv[c + 1][i] = 1'b1;
      end
    for (int j = 0; j < k + int'(ROWS) - 1; j++) begin
      c = shifted(s + 1 + j, stall_at);
      if (ok(c + 1)) e_en[c + 1] = 1;
    end
    last = shifted(s + k + int'(ROWS) - 1, stall_at);
    for (int d = 1; d <= int'(DRAIN); d++)
      if (ok(last + d + 1)) e_en[last + d + 1] = 1;
    for (c = s + 1; c <= last + int'(DRAIN); c++)
      if (ok(c)) e_busy[c] = 1;
    if (ok(last + int'(DRAIN) + 1)) e_done[last + int'(DRAIN) + 1] = 1;
  endtask

  task automatic truncate_from(int from);
    for (int c = from; c < NC; c++) begin
      e_rd[c] = '0; e_fv[c] = '0; e_en[c] = 0; e_busy[c] = 0; e_done[c] = 0;
    end
  endtask

  // Drive n cycles of stimulus, queue expectations, pop and compare mid-cycle
  task automatic run_cycles(int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rst = rs[c]; start = st[c]; k_len = kl[c]; aempty = ae[c]; wempty = we[c];
      sb.push_back('{rd: e_rd[c], fv: e_fv[c], en: e_en[c], bsy: e_busy[c], dn: e_done[c]});
      #1;
      e = sb.pop_front();
      n_cmp += 6;
      if (aread !== e.rd) begin
        n_err++; $display("FAIL %s aread cyc=%0d got=%b want=%b", cur, c, aread, e.rd);
      end
      if (wread !== e.rd) begin
        n_err++; $display("FAIL %s wread cyc=%0d got=%b want=%b", cur, c, wread, e.rd);
      end
      if (feed_valid !== e.fv) begin
        n_err++; $display("FAIL %s feed_valid cyc=%0d got=%b want=%b", cur, c, feed_valid, e.fv);
      end
      if (array_en !== e.en) begin
        n_err++; $display("FAIL %s array_en cyc=%0d got=%b want=%b", cur, c, array_en, e.en);
      end
      if (busy !== e.bsy) begin
        n_err++; $display("FAIL %s busy cyc=%0d got=%b want=%b", cur, c, busy, e.bsy);
      end
      if (done !== e.dn) begin
        n_err++; $display("FAIL %s done cyc=%0d got=%b want=%b", cur, c, done, e.dn);
      end
      for (int i = 0; i < ROWS; i++) rd_cnt[i] += int'(aread[i]);
    end
    start = 0; rst = 0; aempty = '0; wempty = '0;
  endtask

  task automatic check_counts(int want);
    for (int i = 0; i < ROWS; i++) begin
      n_cmp++;
      if (rd_cnt[i] != want) begin
        n_err++; $display("FAIL %s read_count row%0d got=%0d want=%0d", cur, i, rd_cnt[i], want);
      end
    end
  endtask

  task automatic test_reset();
    cur = "reset";
    rst = 1; start = 0; k_len = '0; aempty = '1; wempty = '1;
    repeat (3) @(negedge clk);
    aempty = '0; wempty = '0;
    #1;
    n_cmp++;
    if ({aread, wread, feed_valid, array_en, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset outputs got=%b want=0", {aread, wread, feed_valid, array_en, busy, done});
    end
  endtask

  task automatic test_basic();
    cur = "basic";
    clear_tables();
    st[0] = 1; kl[0] = 8'd3;
    add_tile(0, 3, -1);
    run_cycles(14);
    check_counts(3);
  endtask

  task automatic test_stall();
    cur = "stall";
    clear_tables();
    st[0] = 1; kl[0] = 8'd3;
    ae[4] = 4'b0100;
    add_tile(0, 3, 4);
    run_cycles(15);
    check_counts(3);
  endtask

  task automatic test_inactive_empty();
    cur = "inactive_empty";
    clear_tables();
    st[0] = 1; kl[0] = 8'd3;
    for (int c = 1; c <= 3; c++) we[c] = 4'b1000;
    add_tile(0, 3, -1);
    run_cycles(14);
    check_counts(3);
  endtask

  task automatic test_k_zero();
    cur = "k_zero";
    clear_tables();
    st[0] = 1; kl[0] = 8'd0;
    add_tile(0, 0, -1);
    run_cycles(4);
    check_counts(0);
  endtask

  task automatic test_back_to_back();
    cur = "back_to_back";
    clear_tables();
    st[0] = 1;  kl[0] = 8'd3;
    st[5] = 1;  kl[5] = 8'd1;
    st[11] = 1; kl[11] = 8'd2;
    add_tile(0, 3, -1);
    add_tile(11, 2, -1);
    run_cycles(24);
    check_counts(5);
  endtask

  task automatic test_reset_mid_run();
    cur = "reset_mid_run";
    clear_tables();
    st[0] = 1; kl[0] = 8'd3;
    rs[3] = 1;
    add_tile(0, 3, -1);
    truncate_from(4);
    st[6] = 1; kl[6] = 8'd2;
    add_tile(6, 2, -1);
    run_cycles(20);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_inactive_empty();
    test_k_zero();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
